// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_pkg
// Description : Shared widths, depth defaults and CDB source encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

    localparam int ROB_ID_W_DEF   = 4;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic {
        CDB_SRC_RS  = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

endpackage
`default_nettype wire

// File: rtl/cdb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_result_fifo
// Description : Small per-source result FIFO with push/pop/flush and full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // full/empty come from the pre-edge count only, so a same-edge pop never frees a slot
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = rdy & ~flush & push & ~full;
    assign w_do_pop  = rdy & ~flush & pop & ~empty;
    assign head_data = r_mem[r_head];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_do_push) r_tail <= next_ptr(r_tail);
                if (w_do_pop)  r_head <= next_ptr(r_head);
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_tail] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin share of the registered CDB between RS and LSB results.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int ROB_ID_W   = ROB_ID_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                mispredict,
    input  logic                rs_valid,
    input  logic [ROB_ID_W-1:0] rs_rob_id,
    input  logic [DATA_W-1:0]   rs_value,
    output logic                rs_full,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_value,
    output logic                lsb_full,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_value,
    output logic                cdb_src_lsb,
    output logic                overflow
);
    localparam int ENTRY_W = ROB_ID_W + DATA_W;

    logic [ENTRY_W-1:0] w_rs_head;
    logic [ENTRY_W-1:0] w_lsb_head;
    logic [ENTRY_W-1:0] w_sel_entry;
    logic               w_rs_empty;
    logic               w_lsb_empty;
    logic               w_grant_any;
    logic               w_rs_pop;
    logic               w_lsb_pop;
    logic               w_push_drop;
    cdb_src_e           w_grant_src;
    cdb_src_e           r_rr;

    cdb_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rs_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (mispredict),
        .push      (rs_valid),
        .push_data ({rs_rob_id, rs_value}),
        .pop       (w_rs_pop),
        .head_data (w_rs_head),
        .full      (rs_full),
        .empty     (w_rs_empty)
    );

    cdb_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (mispredict),
        .push      (lsb_valid),
        .push_data ({lsb_rob_id, lsb_value}),
        .pop       (w_lsb_pop),
        .head_data (w_lsb_head),
        .full      (lsb_full),
        .empty     (w_lsb_empty)
    );

    always_comb begin
        w_grant_any = !w_rs_empty || !w_lsb_empty;
        w_grant_src = r_rr;
        if (w_rs_empty) begin
            w_grant_src = CDB_SRC_LSB;
        end else if (w_lsb_empty) begin
            w_grant_src = CDB_SRC_RS;
        end
        w_rs_pop    = w_grant_any && (w_grant_src == CDB_SRC_RS);
        w_lsb_pop   = w_grant_any && (w_grant_src == CDB_SRC_LSB);
        w_sel_entry = (w_grant_src == CDB_SRC_LSB) ? w_lsb_head : w_rs_head;
        w_push_drop = (rs_valid && rs_full) || (lsb_valid && lsb_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid   <= 1'b0;
            cdb_rob_id  <= '0;
            cdb_value   <= '0;
            cdb_src_lsb <= 1'b0;
            overflow    <= 1'b0;
            r_rr        <= CDB_SRC_RS;
        end else if (rdy) begin
            if (mispredict) begin
                cdb_valid <= 1'b0;
                r_rr      <= CDB_SRC_RS;
            end else begin
                if (w_push_drop) overflow <= 1'b1;
                if (w_grant_any) begin
                    cdb_valid   <= 1'b1;
                    cdb_rob_id  <= w_sel_entry[ENTRY_W-1 -: ROB_ID_W];
                    cdb_value   <= w_sel_entry[DATA_W-1:0];
                    cdb_src_lsb <= (w_grant_src == CDB_SRC_LSB);
                    // hand priority to whichever side did not just win
                    r_rr        <= (w_grant_src == CDB_SRC_LSB) ? CDB_SRC_RS : CDB_SRC_LSB;
                end else begin
                    cdb_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Queue-based reference model bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cdb_arbiter;
    localparam int ROB_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                rdy;
    logic                mispredict;
    logic                rs_valid;
    logic [ROB_ID_W-1:0] rs_rob_id;
    logic [DATA_W-1:0]   rs_value;
    logic                rs_full;
    logic                lsb_valid;
    logic [ROB_ID_W-1:0] lsb_rob_id;
    logic [DATA_W-1:0]   lsb_value;
    logic                lsb_full;
    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [DATA_W-1:0]   cdb_value;
    logic                cdb_src_lsb;
    logic                overflow;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [ROB_ID_W-1:0] id;
        logic [DATA_W-1:0]   val;
    } ent_t;

    ent_t                rs_q[$];
    ent_t                lsb_q[$];
    logic [4:0]          obs[$];
    logic                m_valid;
    logic                m_src;
    logic                m_ovf;
    logic [ROB_ID_W-1:0] m_id;
    logic [DATA_W-1:0]   m_val;
    bit                  m_rr_lsb;

    cdb_arbiter #(
        .ROB_ID_W   (ROB_ID_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .mispredict  (mispredict),
        .rs_valid    (rs_valid),
        .rs_rob_id   (rs_rob_id),
        .rs_value    (rs_value),
        .rs_full     (rs_full),
        .lsb_valid   (lsb_valid),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_value   (lsb_value),
        .lsb_full    (lsb_full),
        .cdb_valid   (cdb_valid),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_value   (cdb_value),
        .cdb_src_lsb (cdb_src_lsb),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rs_q.delete();
        lsb_q.delete();
        m_valid  = 1'b0;
        m_src    = 1'b0;
        m_ovf    = 1'b0;
        m_id     = '0;
        m_val    = '0;
        m_rr_lsb = 1'b0;
    endtask

    // One clock edge of the reference: pop decided from pre-edge occupancy, pushes appended after.
    task automatic model_edge();
        ent_t e;
        bit   rs_f;
        bit   lsb_f;
        bit   take_lsb;
        if (!rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        if (mispredict) begin
            rs_q.delete();
            lsb_q.delete();
            m_valid  = 1'b0;
            m_rr_lsb = 1'b0;
            return;
        end
        rs_f  = (rs_q.size() == DEPTH);
        lsb_f = (lsb_q.size() == DEPTH);
        if (rs_q.size() == 0 && lsb_q.size() == 0) begin
            m_valid = 1'b0;
        end else begin
            if (rs_q.size() == 0)       take_lsb = 1'b1;
            else if (lsb_q.size() == 0) take_lsb = 1'b0;
            else                        take_lsb = m_rr_lsb;
            e        = take_lsb ? lsb_q.pop_front() : rs_q.pop_front();
            m_valid  = 1'b1;
            m_id     = e.id;
            m_val    = e.val;
            m_src    = take_lsb;
            m_rr_lsb = !take_lsb;
        end
        if (rs_valid) begin
            if (rs_f) m_ovf = 1'b1;
            else      rs_q.push_back({rs_rob_id, rs_value});
        end
        if (lsb_valid) begin
            if (lsb_f) m_ovf = 1'b1;
            else       lsb_q.push_back({lsb_rob_id, lsb_value});
        end
    endtask

    task automatic check_all();
        chk("cdb_valid",   cdb_valid,   m_valid);
        chk("cdb_rob_id",  cdb_rob_id,  m_id);
        chk("cdb_value",   cdb_value,   m_val);
        chk("cdb_src_lsb", cdb_src_lsb, m_src);
        chk("rs_full",     rs_full,     rs_q.size() == DEPTH);
        chk("lsb_full",    lsb_full,    lsb_q.size() == DEPTH);
        chk("overflow",    overflow,    m_ovf);
        if (cdb_valid === 1'b1) obs.push_back({cdb_src_lsb, cdb_rob_id});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit rv, input logic [3:0] rid, input logic [31:0] rval,
                         input bit lv, input logic [3:0] lid, input logic [31:0] lval,
                         input bit rd, input bit mp);
        rs_valid   = rv;
        rs_rob_id  = rid;
        rs_value   = rval;
        lsb_valid  = lv;
        lsb_rob_id = lid;
        lsb_value  = lval;
        rdy        = rd;
        mispredict = mp;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic flush_cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step();
    endtask

    int rs_bc;
    bit saw7;

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        repeat (2) step();
        chk("reset_valid", cdb_valid, 0);
        chk("reset_full",  rs_full,   0);
        chk("reset_ovf",   overflow,  0);
        rst = 1'b1;

        // single source latency
        drive(1, 4'd3, 32'h11, 0, 0, 0, 1, 0);
        step();
        chk("single_e1_valid", cdb_valid, 0);
        idle();
        step();
        chk("single_valid", cdb_valid, 1);
        chk("single_id",    cdb_rob_id, 4'd3);
        chk("single_val",   cdb_value,  32'h11);
        chk("single_src",   cdb_src_lsb, 0);
        step();
        chk("single_done", cdb_valid, 0);

        // contention: expect 1,5,2,6
        flush_cycle();
        obs.delete();
        drive(1, 4'd1, 32'h100, 1, 4'd5, 32'h500, 1, 0);
        step();
        drive(1, 4'd2, 32'h200, 1, 4'd6, 32'h600, 1, 0);
        step();
        idle();
        repeat (4) step();
        chk("cont_count", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("cont_0", obs[0], 5'h01);
            chk("cont_1", obs[1], 5'h15);
            chk("cont_2", obs[2], 5'h02);
            chk("cont_3", obs[3], 5'h16);
        end
        chk("cont_end", cdb_valid, 0);

        // stall with pending entries and a live broadcast
        flush_cycle();
        drive(1, 4'd4, 32'h44, 1, 4'd8, 32'h88, 1, 0);
        step();
        drive(1, 4'd9, 32'h99, 1, 4'd10, 32'haa, 1, 0);
        step();
        drive(1, 4'd11, 32'hbb, 0, 0, 0, 1, 0);
        step();
        chk("stall_pre_full",  rs_full,   1);
        chk("stall_pre_valid", cdb_valid, 1);
        drive(1, 4'd12, 32'hcc, 1, 4'd13, 32'hdd, 0, 0);
        repeat (3) step();
        chk("stall_ovf",   overflow,   0);
        chk("stall_full",  rs_full,    1);
        chk("stall_id",    cdb_rob_id, 4'd8);
        chk("stall_valid", cdb_valid,  1);
        idle();
        obs.delete();
        repeat (5) step();
        chk("stall_count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("stall_0", obs[0], 5'h09);
            chk("stall_1", obs[1], 5'h1a);
            chk("stall_2", obs[2], 5'h0b);
        end

        // full / overflow
        flush_cycle();
        obs.delete();
        drive(1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 1, 0);
        step();
        drive(1, 4'd3, 32'h3, 1, 4'd4, 32'h4, 1, 0);
        step();
        drive(1, 4'd5, 32'h5, 0, 0, 0, 1, 0);
        step();
        chk("ovf_full", rs_full,  1);
        chk("ovf_pre",  overflow, 0);
        drive(1, 4'd6, 32'h6, 0, 0, 0, 1, 0);
        step();
        chk("ovf_set", overflow, 1);
        idle();
        repeat (6) step();
        rs_bc = 0;
        foreach (obs[k]) if (obs[k][4] == 1'b0) rs_bc++;
        chk("ovf_rs_bc", rs_bc, 3);

        // flush with concurrent push of id 7
        flush_cycle();
        drive(1, 4'd1, 32'h1, 1, 4'd2, 32'h2, 1, 0);
        step();
        drive(1, 4'd3, 32'h3, 1, 4'd4, 32'h4, 1, 0);
        step();
        drive(1, 4'd5, 32'h5, 0, 0, 0, 1, 0);
        step();
        drive(1, 4'd7, 32'h77, 0, 0, 0, 1, 1);
        step();
        chk("flush_valid",    cdb_valid, 0);
        chk("flush_rs_full",  rs_full,   0);
        chk("flush_lsb_full", lsb_full,  0);
        idle();
        obs.delete();
        repeat (3) step();
        saw7 = 1'b0;
        foreach (obs[k]) if (obs[k][3:0] == 4'd7) saw7 = 1'b1;
        chk("flush_no7", saw7, 0);
        drive(1, 4'd1, 32'h1, 1, 4'd9, 32'h9, 1, 0);
        step();
        idle();
        repeat (3) step();
        chk("flush_rr_count", obs.size(), 2);
        if (obs.size() >= 1) chk("flush_rr_first", obs[0], 5'h01);

        // asynchronous reset in the middle of a broadcast
        drive(1, 4'd2, 32'h2, 1, 4'd3, 32'h3, 1, 0);
        step();
        drive(1, 4'd4, 32'h4, 1, 4'd5, 32'h5, 1, 0);
        step();
        idle();
        chk("arst_pre_valid", cdb_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid",    cdb_valid, 0);
        chk("arst_rs_full",  rs_full,   0);
        chk("arst_lsb_full", lsb_full,  0);
        chk("arst_ovf",      overflow,  0);
        model_reset();
        step();
        rst = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            rdy        = ($urandom_range(0, 99) < 90);
            mispredict = ($urandom_range(0, 99) < 3);
            rs_valid   = (rs_q.size() < DEPTH)  ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            lsb_valid  = (lsb_q.size() < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            rs_rob_id  = 4'($urandom);
            rs_value   = $urandom;
            lsb_rob_id = 4'($urandom);
            lsb_value  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
